// File: rtl/clk_div_pkg.sv
// clk_div_pkg: FSM states, divisor floor and phase helper shared by the clock divider
package clk_div_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int DIV_MIN = 2;
  function automatic int unsigned half_lo(input int unsigned d);
    return d >> 1;
  endfunction
endpackage

// File: rtl/clk_div_outgen.sv
// clk_div_outgen: merges the rising- and falling-edge phases into a 50%-duty clk_out
module clk_div_outgen #(
  parameter bit USE_BUFG = 1
) (
  input  logic clk_in,
  input  logic rstn,
  input  logic q_pos,
  input  logic odd,
  output logic clk_out
);
  logic q_neg, clk_comb;
  // half-cycle extension of the high phase, only meaningful for odd divisors
  always_ff @(negedge clk_in or negedge rstn)
    if (!rstn) q_neg <= 1'b0;
    else q_neg <= q_pos & odd;
  assign clk_comb = q_pos | q_neg;
  if (USE_BUFG) begin : g_bufg
    clk_div_bufg u_bufg (.i(clk_comb), .o(clk_out));
  end else begin : g_direct
    assign clk_out = clk_comb;
  end
endmodule

module clk_div_bufg (
  input  logic i,
  output logic o
);
  // behavioural global clock buffer; the implementation flow maps it to the vendor BUFG
  assign o = i;
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable even/odd clock divider with boundary-aligned divisor updates
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int W        = 8,
  parameter int DIV_INIT = 4,
  parameter bit USE_BUFG = 1
) (
  input  logic         clk_in,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] cfg_div,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  output logic [W-1:0] div_cur,
  output logic         running,
  output logic         clk_out,
  output logic         tick_rise,
  output logic         tick_fall
);
  state_t state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt, div_nxt, pend;
  logic pend_v, xfer, last, apply, q_pos, q_pos_nxt;
  assign xfer  = cfg_valid & ~pend_v;
  assign last  = cnt == div_cur - W'(1);
  assign apply = pend_v & ((state == IDLE) | last);
  always_ff @(posedge clk_in or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  // q_pos is registered from next-state values so clk_out never sees a decode glitch
  always_comb begin
    state_nxt = state == IDLE ? (en ? RUN : IDLE) : ((last & ~en) ? IDLE : RUN);
    cnt_nxt   = ((state == RUN) & ~last) ? cnt + W'(1) : '0;
    div_nxt   = apply ? pend : div_cur;
    q_pos_nxt = (state_nxt == RUN) & (cnt_nxt < W'(half_lo(32'(div_nxt))));
  end
  always_ff @(posedge clk_in or negedge rstn)
    if (!rstn) begin
      cnt     <= '0;
      div_cur <= W'(DIV_INIT);
      pend    <= '0;
      pend_v  <= 1'b0;
      q_pos   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      div_cur <= div_nxt;
      q_pos   <= q_pos_nxt;
      pend_v  <= xfer | (pend_v & ~apply);
      if (xfer) pend <= (cfg_div < W'(DIV_MIN)) ? W'(DIV_MIN) : cfg_div;
    end
  always_comb begin
    running   = state == RUN;
    cfg_ready = ~pend_v;
    tick_rise = running & (cnt == '0);
    tick_fall = running & (cnt == W'(half_lo(32'(div_cur))));
  end
  clk_div_outgen #(.USE_BUFG(USE_BUFG)) u_outgen (
    .clk_in (clk_in),
    .rstn   (rstn),
    .q_pos  (q_pos),
    .odd    (div_cur[0]),
    .clk_out(clk_out)
  );
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed plus random stimulus against a period-level model of the divider
module tb_clk_div_prog;
  timeunit 1ns;
  timeprecision 100ps;
  logic clk_in = 1'b0, rstn = 1'b0, en = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_div = '0;
  logic cfg_ready, running, clk_out, tick_rise, tick_fall;
  logic [7:0] div_cur;
  int checks = 0, errors = 0;
  int m_run = 0, m_p = 0, m_d = 4;
  int pq[$];
  time t_rise = 0, t_fall = 0;
  int n_rise = 0, n0;

  clk_div_prog dut (
    .clk_in(clk_in), .rstn(rstn), .en(en), .cfg_div(cfg_div), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .div_cur(div_cur), .running(running), .clk_out(clk_out),
    .tick_rise(tick_rise), .tick_fall(tick_fall)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_out) begin
    t_rise = $time;
    n_rise++;
  end
  always @(negedge clk_out) t_fall = $time;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // clk_out is high for the first D half-cycles of each period
  task automatic check_state(input int half);
    chk("running", running, m_run != 0);
    chk("div_cur", div_cur, m_d);
    chk("cfg_ready", cfg_ready, pq.size() == 0);
    chk("tick_rise", tick_rise, m_run != 0 && m_p == 0);
    chk("tick_fall", tick_fall, m_run != 0 && m_p == m_d / 2);
    chk(half != 0 ? "clk_out_2nd_half" : "clk_out_1st_half", clk_out, m_run != 0 && 2 * m_p + half < m_d);
  endtask

  task automatic cyc(input logic e, input logic v, input int d);
    int nd;
    logic bnd, rdy;
    en = e;
    cfg_valid = v;
    cfg_div = 8'(d);
    @(posedge clk_in);
    rdy = pq.size() == 0;
    bnd = m_run != 0 && m_p == m_d - 1;
    nd = m_d;
    if (!rdy && (m_run == 0 || bnd)) nd = pq.pop_front();
    if (v && rdy) pq.push_back(d < 2 ? 2 : d);
    if (m_run == 0 || bnd) begin
      m_run = e;
      m_p = 0;
    end else m_p++;
    m_d = nd;
    #1 check_state(0);
    @(negedge clk_in);
    #1 check_state(1);
  endtask

  task automatic run_until(input int dd, input int pp);
    for (int i = 0; i < 600; i++) begin
      if (m_run != 0 && m_d == dd && m_p == pp) break;
      cyc(1, 0, 0);
    end
  endtask

  initial begin
    #12;
    chk("rst_ready", cfg_ready, 1);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_running", running, 0);
    chk("rst_tick_rise", tick_rise, 0);
    chk("rst_tick_fall", tick_fall, 0);
    chk("rst_div_cur", div_cur, 4);
    #9 rstn = 1'b1;
    repeat (13) cyc(1, 0, 0);
    cyc(1, 1, 3);
    run_until(3, 0);
    n0 = n_rise;
    repeat (9) cyc(1, 0, 0);
    chk("odd_rise_count", n_rise - n0, 3);
    run_until(3, 2);
    chk("odd_high_time", t_fall - t_rise, 15);
    cyc(1, 1, 4);
    run_until(4, 1);
    cyc(1, 1, 7);
    cyc(1, 1, 9);
    repeat (20) cyc(1, 0, 0);
    cyc(1, 1, 0);
    repeat (8) cyc(1, 0, 0);
    cyc(1, 1, 1);
    repeat (8) cyc(1, 0, 0);
    cyc(1, 1, 255);
    repeat (520) cyc(1, 0, 0);
    cyc(1, 1, 6);
    run_until(6, 1);
    repeat (13) cyc(0, 0, 0);
    repeat (8) cyc(1, 0, 0);
    cyc(1, 1, 5);
    run_until(5, 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_clk_out", clk_out, 0);
    chk("mid_rst_tick_rise", tick_rise, 0);
    chk("mid_rst_tick_fall", tick_fall, 0);
    chk("mid_rst_div_cur", div_cur, 4);
    chk("mid_rst_ready", cfg_ready, 1);
    chk("mid_rst_running", running, 0);
    m_run = 0;
    m_p = 0;
    m_d = 4;
    pq.delete();
    @(negedge clk_in);
    #1 rstn = 1'b1;
    repeat (1500)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
